// File: rtl/mod53_residue_accumulator_if.sv
// mod53_residue_accumulator_if: residue input and frame-result handshakes of the mod-53 accumulator.
interface mod53_residue_accumulator_if #(parameter int CNT_W = 4);
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       in_res;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [5:0]       out_res;
  logic [CNT_W-1:0] out_cnt;
  logic             err;
  modport master (output in_valid, in_res, in_last, out_ready,
                  input in_ready, out_valid, out_res, out_cnt, err);
  modport slave (input in_valid, in_res, in_last, out_ready,
                 output in_ready, out_valid, out_res, out_cnt, err);
endinterface

// File: rtl/mod53_residue_accumulator.sv
// mod53_residue_accumulator: sums up to N_TERMS residues mod 53 per frame, registered result handshake.
// Define MOD53_ACC_RANGE_CHECK_EN to zero out-of-range terms and raise a sticky err instead of pre-reducing them.
module mod53_residue_accumulator #(
  parameter int N_TERMS = 8,
  parameter int CNT_W = 4
) (
  input logic clk,
  input logic rst_n,
  mod53_residue_accumulator_if.slave bus
);
  typedef enum logic {ACC, OUT} state_t;
  state_t r_state, w_state_n;
  logic r_in_ready, r_out_valid;
  logic [5:0] r_acc, r_out_res, w_term, w_acc_n;
  logic [CNT_W-1:0] r_cnt, r_out_cnt, w_cnt_n;
  logic [6:0] w_sum;
  logic w_accept, w_oor, w_end;
  assign w_accept = bus.in_valid & r_in_ready;
  assign w_oor = bus.in_res >= 6'd53;
`ifdef MOD53_ACC_RANGE_CHECK_EN
  logic r_err;
  assign w_term = w_oor ? 6'd0 : bus.in_res;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_err <= 1'b0;
    else r_err <= r_err | (w_accept & w_oor);
  assign bus.err = r_err;
`else
  assign w_term = w_oor ? bus.in_res - 6'd53 : bus.in_res;
  assign bus.err = 1'b0;
`endif
  // both operands are at most 52, so one conditional subtract fully reduces the sum
  assign w_sum = {1'b0, r_acc} + {1'b0, w_term};
  assign w_acc_n = 6'(w_sum >= 7'd53 ? w_sum - 7'd53 : w_sum);
  assign w_cnt_n = r_cnt + CNT_W'(1);
  assign w_end = w_accept & ((r_cnt == CNT_W'(N_TERMS - 1)) | bus.in_last);
  always_comb begin
    w_state_n = r_state;
    w_state_n = (r_state == ACC) ? (w_end ? OUT : ACC) : (bus.out_ready ? ACC : OUT);
  end
  // handshake flags are registered from the next state so they come up one cycle after reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= ACC;
      r_in_ready <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_in_ready <= w_state_n == ACC;
      r_out_valid <= w_state_n == OUT;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_out_res <= '0;
      r_out_cnt <= '0;
    end else if (w_end) begin
      r_out_res <= w_acc_n;
      r_out_cnt <= w_cnt_n;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_acc <= w_acc_n;
      r_cnt <= w_cnt_n;
    end
  assign bus.in_ready = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_res = r_out_res;
  assign bus.out_cnt = r_out_cnt;
endmodule

// File: tb/tb_mod53_residue_accumulator.sv
// tb_mod53_residue_accumulator: vector table, hand-written corner sequences and random frames vs. an arithmetic model.
module tb_mod53_residue_accumulator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  logic m_err = 1'b0;
  always #5 clk = ~clk;
  mod53_residue_accumulator_if #(.CNT_W(4)) bus();
  mod53_residue_accumulator #(.N_TERMS(8), .CNT_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  typedef struct packed {
    logic [7:0][5:0] res;
    logic [3:0] n;
    logic last;
    logic gap;
    logic [5:0] exp_res;
    logic [3:0] exp_cnt;
  } vec_t;
  vec_t tbl[10];
  function automatic vec_t mk(input logic [5:0] base, step, input logic [3:0] n, input logic last, gap,
                              input logic [5:0] er, input logic [3:0] ec);
    vec_t v;
    for (int i = 0; i < 8; i++) v.res[i] = base + step * 6'(i);
    v.n = n;
    v.last = last;
    v.gap = gap;
    v.exp_res = er;
    v.exp_cnt = ec;
    return v;
  endfunction
  function automatic int norm(input int r);
`ifdef MOD53_ACC_RANGE_CHECK_EN
    return r >= 53 ? 0 : r;
`else
    return r >= 53 ? r - 53 : r;
`endif
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic send(input logic [5:0] r, input logic l);
    int k = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_res = r;
    bus.in_last = l;
    while (!bus.in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready never rose within %0d cycles", k);
    end else begin
      @(posedge clk);
      #1;
`ifdef MOD53_ACC_RANGE_CHECK_EN
      if (r >= 53) m_err = 1'b1;
`endif
    end
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
  endtask
  task automatic handshake();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("valid_drop", bus.out_valid, 0);
    chk("ready_back", bus.in_ready, 1);
  endtask
  task automatic run_frame(input logic [7:0][5:0] res, input int n, input logic last, input logic gap,
                           input logic [5:0] er, input logic [3:0] ec);
    for (int i = 0; i < n; i++) begin
      send(res[i], last && i == n - 1);
      if (i < n - 1) begin
        chk("early_valid", bus.out_valid, 0);
        if (gap) @(negedge clk);
      end
    end
    chk("out_valid", bus.out_valid, 1);
    chk("out_res", bus.out_res, er);
    chk("out_cnt", bus.out_cnt, ec);
    chk("err", bus.err, m_err);
    handshake();
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0][5:0] rr;
    int n, sum;
    logic lst, gp;
    bus.in_valid = 1'b0;
    bus.in_res = '0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b0;
    tbl[0] = mk(6'd52, 6'd0, 4'd8, 1'b0, 1'b0, 6'd45, 4'd8);
    tbl[1] = mk(6'd1, 6'd1, 4'd8, 1'b0, 1'b0, 6'd36, 4'd8);
    tbl[2] = mk(6'd1, 6'd1, 4'd8, 1'b0, 1'b1, 6'd36, 4'd8);
    tbl[3] = mk(6'd30, 6'd0, 4'd3, 1'b1, 1'b0, 6'd37, 4'd3);
    tbl[4] = mk(6'd5, 6'd0, 4'd1, 1'b1, 1'b0, 6'd5, 4'd1);
    tbl[5] = mk(6'd1, 6'd1, 4'd8, 1'b1, 1'b0, 6'd36, 4'd8);
    tbl[6] = mk(6'd52, 6'd0, 4'd1, 1'b1, 1'b1, 6'd52, 4'd1);
    tbl[7] = mk(6'd26, 6'd1, 4'd2, 1'b1, 1'b0, 6'd0, 4'd2);
    tbl[8] = mk(6'd0, 6'd0, 4'd4, 1'b1, 1'b1, 6'd0, 4'd4);
`ifdef MOD53_ACC_RANGE_CHECK_EN
    tbl[9] = mk(6'd60, 6'd0, 4'd2, 1'b1, 1'b0, 6'd10, 4'd2);
`else
    tbl[9] = mk(6'd60, 6'd0, 4'd2, 1'b1, 1'b0, 6'd17, 4'd2);
`endif
    tbl[9].res[1] = 6'd10;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_res", bus.out_res, 0);
    chk("rst_out_cnt", bus.out_cnt, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", bus.in_ready, 1);
    for (int v = 0; v < 10; v++)
      run_frame(tbl[v].res, int'(tbl[v].n), tbl[v].last, tbl[v].gap, tbl[v].exp_res, tbl[v].exp_cnt);
    for (int i = 1; i <= 8; i++) send(6'(i), 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_res", bus.out_res, 36);
      chk("bp_cnt", bus.out_cnt, 8);
      chk("bp_in_ready", bus.in_ready, 0);
      bus.in_valid = (k % 2) == 0;
      bus.in_res = 6'd7;
      bus.in_last = 1'b1;
    end
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    handshake();
    rr = '0;
    rr[0] = 6'd3;
    run_frame(rr, 1, 1'b1, 1'b0, 6'd3, 4'd1);
    for (int f = 0; f < 40; f++) begin
      n = $urandom_range(1, 8);
      lst = (n < 8) ? 1'b1 : 1'($urandom_range(0, 1));
      gp = 1'($urandom_range(0, 1));
      sum = 0;
      for (int i = 0; i < 8; i++) begin
        rr[i] = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(53, 63)) : 6'($urandom_range(0, 52));
        if (i < n) sum += norm(int'(rr[i]));
      end
      run_frame(rr, n, lst, gp, 6'(sum % 53), 4'(n));
    end
    for (int i = 0; i < 4; i++) send(6'd50, 1'b0);
    #2;
    rst_n = 1'b0;
    m_err = 1'b0;
    #1;
    chk("midrst_valid", bus.out_valid, 0);
    chk("midrst_res", bus.out_res, 0);
    chk("midrst_cnt", bus.out_cnt, 0);
    chk("midrst_err", bus.err, 0);
    chk("midrst_in_ready", bus.in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    chk("release_ready_up", bus.in_ready, 1);
    run_frame(tbl[0].res & '0 | {8{6'd1}}, 8, 1'b0, 1'b0, 6'd8, 4'd8);
    send(6'd60, 1'b1);
    chk("oor_valid", bus.out_valid, 1);
    chk("oor_err", bus.err, m_err);
    #2;
    rst_n = 1'b0;
    m_err = 1'b0;
    #1;
    chk("outrst_valid", bus.out_valid, 0);
    chk("outrst_err", bus.err, 0);
    chk("outrst_res", bus.out_res, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rr = '0;
    rr[0] = 6'd5;
    run_frame(rr, 1, 1'b1, 1'b0, 6'd5, 4'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mod53_residue_accumulator.md
Name: mod53_residue_accumulator

Overview:
- Sequential mod-53 accumulator sitting directly downstream of the x_400 constant-multiply LUT stages.
- Consumes one 6-bit residue per accepted handshake: the product digit reduced mod 53.
- Sums N_TERMS residues, or fewer if in_last is asserted, and returns the total mod 53 through a registered valid/ready output.
- Closes one residue channel of the modular calculator.

Parameters:
N_TERMS, 8, number of residue terms per accumulation frame (1..15)
CNT_W, 4, term counter width; must satisfy 2**CNT_W > N_TERMS

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream residue valid
in_ready  output  1  block can accept a residue this cycle
in_res  input  6  residue from the LUT stage, nominally 0..52
in_last  input  1  final term of the frame (early termination)
out_valid  output  1  frame result valid
out_ready  input  1  downstream accepts the result
out_res  output  6  accumulated sum mod 53, always 0..52
out_cnt  output  CNT_W  number of terms in the completed frame
err  output  1  sticky range error (only with the optional feature; otherwise tied 0)

Behaviour:
- Reset (async, rst_n=0):
  - state=ACC; acc=0; cnt=0.
  - out_valid=0, out_res=0, out_cnt=0, err=0.
  - in_ready goes to 1 one cycle after rst_n deasserts.
- States:
  - ACC: in_ready=1.
  - OUT: in_ready=0, out_valid=1.
- Accept = in_valid & in_ready. In ACC, each accept:
  - term = in_res, normalised per the optional-feature rules.
  - sum = acc + term, 7-bit, max 104.
  - acc_n = (sum >= 53) ? sum - 53 : sum. This single conditional subtract is sufficient because both operands are <= 52.
  - cnt increments.
- Frame end = accept with (cnt == N_TERMS-1) or in_last=1. On that edge:
  - out_res <= acc_n; out_cnt <= cnt+1.
  - acc <= 0; cnt <= 0; state <= OUT.
  - out_valid rises on the following cycle. Latency is 1 clock from the final accept.
- OUT:
  - out_res and out_cnt are held stable while out_valid=1 and out_ready=0.
  - out_valid & out_ready -> state ACC next cycle, out_valid=0.
  - No new input is accepted during the handshake cycle; the back-to-back frame gap is 1 cycle minimum.
- in_last with N_TERMS=1, or in_last on the counter-terminal term: identical single frame end, no double count.
- in_valid is ignored in OUT. Upstream holds its data, per standard valid/ready rules.
- out_ready asserted while out_valid=0: no effect.
- Reset mid-frame or mid-OUT: partial sum discarded, all state cleared, no spurious out_valid.
- No combinational path from in_* to out_*. in_ready depends only on state.

Optional Feature:
- Macro: MOD53_ACC_RANGE_CHECK_EN.
- Defined:
  - An accepted in_res >= 53 sets err=1. err is sticky and cleared only by reset.
  - That term contributes 0 but is still counted toward cnt and frame end.
- Undefined:
  - in_res >= 53 is pre-reduced by one subtract of 53 (e.g. 60 -> 7, 63 -> 10) before addition.
  - err is tied 0.

Test Plan:
- Full frame of 8 accepts, each in_res=52, out_ready=1 -> out_res=45 (416 mod 53), out_cnt=8, out_valid exactly one cycle after the 8th accept.
- Terms 1..8 -> out_res=36, out_cnt=8. Repeat with a 1-cycle idle (in_valid=0) between every term -> same result.
- Three terms of 30, in_last on the third -> out_res=37, out_cnt=3. Next frame starts from acc=0: single term 5 with in_last -> out_res=5, out_cnt=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_res/out_cnt stable, in_ready=0, in_valid pulses ignored. Release -> out_valid drops next cycle and in_ready=1.
- Out-of-range input: frame {60, 10, in_last} ->
  - without macro: out_res=17, err=0;
  - with MOD53_ACC_RANGE_CHECK_EN: out_res=10, out_cnt=2, err=1, and err stays 1 across later frames until reset.
- Assert rst_n=0 after 4 accepts of 50 (asynchronous, mid-cycle) -> outputs zero immediately. After release, a full 8×1 frame gives out_res=8.
